// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, opcode constants and handshake state encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b001;
  localparam logic [2:0] OP_LDB  = 3'b010;
  localparam logic [2:0] OP_ALU3 = 3'b011;
  localparam logic [2:0] OP_ALU4 = 3'b100;
  localparam logic [2:0] OP_ALU5 = 3'b101;
  localparam logic [2:0] OP_ALU6 = 3'b110;
  localparam logic [2:0] OP_ALU7 = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/operand_reg.sv
`default_nettype none
// ============================================================================
// Module   : operand_reg
// Purpose  : One operand register with clear/load and a loaded flag.
// Revision : 1.0
// ============================================================================
module operand_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  clr_flag,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  loaded
);

  // clear outranks load; clr_flag only drops the loaded flag, keeping the data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      loaded <= 1'b0;
    end else if (clr) begin
      q      <= '0;
      loaded <= 1'b0;
    end else if (load) begin
      q      <= data_in;
      loaded <= 1'b1;
    end else if (clr_flag) begin
      loaded <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_register_unit.sv
`default_nettype none
// ============================================================================
// Module   : operand_register_unit
// Purpose  : Operand registers A/B with valid/ready issue of operand pairs to the ALU.
// Revision : 1.0
// ============================================================================
module operand_register_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter bit CLEAR_ON_ISSUE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  write_A,
  input  logic                  write_B,
  input  logic                  reset_A,
  input  logic                  reset_B,
  input  logic                  read_A,
  input  logic                  read_B,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] operand_A,
  output logic [DATA_WIDTH-1:0] operand_B,
  output logic [2:0]            alu_op,
  output logic                  op_valid,
  input  logic                  alu_ready,
  output logic                  A_loaded,
  output logic                  B_loaded,
  output logic                  read_error
);

  state_t state, state_next;
  logic   accept, any_read, any_mod, issue_go, read_bad, flag_clr;

  assign accept   = cmd_valid && (state == IDLE);
  assign any_read = read_A || read_B;
  assign any_mod  = write_A || write_B || reset_A || reset_B;
  // a read mixed with any write/reset is always an error, even if both are loaded
  assign issue_go = accept && any_read && !any_mod && A_loaded && B_loaded;
  assign read_bad = accept && any_read && !issue_go;
  assign flag_clr = CLEAR_ON_ISSUE && (state == ISSUE) && alu_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (issue_go) state_next = ISSUE;
      end
      ISSUE: begin
        if (alu_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_valid   <= 1'b0;
      read_error <= 1'b0;
      alu_op     <= '0;
    end else begin
      op_valid   <= (state_next == ISSUE);
      read_error <= read_bad;
      if (issue_go) alu_op <= opcode;
    end
  end

  operand_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg_a (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept && reset_A),
    .load     (accept && write_A),
    .clr_flag (flag_clr),
    .data_in  (data_in),
    .q        (operand_A),
    .loaded   (A_loaded)
  );

  operand_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg_b (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept && reset_B),
    .load     (accept && write_B),
    .clr_flag (flag_clr),
    .data_in  (data_in),
    .q        (operand_B),
    .loaded   (B_loaded)
  );

endmodule
`default_nettype wire

// File: tb/tb_operand_register_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_register_unit
// Purpose  : Vector table plus corner-case sequences for operand_register_unit.
// Revision : 1.0
// ============================================================================
module tb_operand_register_unit;

  typedef struct {
    logic        cv, wa, wb, ra, rb, rda, rdb, ardy;
    logic [2:0]  op;
    logic [31:0] din;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
    logic        ev, ela, elb, eerr;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic cmd_valid = 0, write_A = 0, write_B = 0, reset_A = 0, reset_B = 0;
  logic read_A = 0, read_B = 0, alu_ready = 0;
  logic [2:0]  opcode = '0;
  logic [31:0] data_in = '0;

  logic        rdy0, v0, la0, lb0, err0, rdy1, v1, la1, lb1, err1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;

  int checks = 0, errors = 0;
  vec_t sb[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  operand_register_unit #(.DATA_WIDTH(32), .CLEAR_ON_ISSUE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .write_A(write_A), .write_B(write_B), .reset_A(reset_A), .reset_B(reset_B),
    .read_A(read_A), .read_B(read_B), .opcode(opcode), .data_in(data_in),
    .operand_A(a0), .operand_B(b0), .alu_op(op0), .op_valid(v0),
    .alu_ready(alu_ready), .A_loaded(la0), .B_loaded(lb0), .read_error(err0));

  operand_register_unit #(.DATA_WIDTH(32), .CLEAR_ON_ISSUE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .write_A(write_A), .write_B(write_B), .reset_A(reset_A), .reset_B(reset_B),
    .read_A(read_A), .read_B(read_B), .opcode(opcode), .data_in(data_in),
    .operand_A(a1), .operand_B(b1), .alu_op(op1), .op_valid(v1),
    .alu_ready(alu_ready), .A_loaded(la1), .B_loaded(lb1), .read_error(err1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cv, wa, wb, ra, rb, rda, rdb, ardy,
                              input logic [2:0] op, input logic [31:0] din,
                              input logic [31:0] ea, eb, input logic [2:0] eop,
                              input logic ev, ela, elb, eerr);
    vec_t v;
    v.cv = cv; v.wa = wa; v.wb = wb; v.ra = ra; v.rb = rb;
    v.rda = rda; v.rdb = rdb; v.ardy = ardy; v.op = op; v.din = din;
    v.ea = ea; v.eb = eb; v.eop = eop; v.ev = ev;
    v.ela = ela; v.elb = elb; v.eerr = eerr;
    return v;
  endfunction

  // drive one cycle, queue its expectation, compare dut0 after the edge
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    cmd_valid = v.cv; write_A = v.wa; write_B = v.wb; reset_A = v.ra; reset_B = v.rb;
    read_A = v.rda; read_B = v.rdb; alu_ready = v.ardy; opcode = v.op; data_in = v.din;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " operand_A"}, a0, e.ea);
    chk({tag, " operand_B"}, b0, e.eb);
    chk({tag, " alu_op"}, {29'd0, op0}, {29'd0, e.eop});
    chk({tag, " op_valid"}, {31'd0, v0}, {31'd0, e.ev});
    chk({tag, " A_loaded"}, {31'd0, la0}, {31'd0, e.ela});
    chk({tag, " B_loaded"}, {31'd0, lb0}, {31'd0, e.elb});
    chk({tag, " read_error"}, {31'd0, err0}, {31'd0, e.eerr});
    chk({tag, " cmd_ready"}, {31'd0, rdy0}, {31'd0, !e.ev});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    //            cv wa wb ra rb rA rB ar op      din            A             B             aop     v  la lb er
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h5,        32'h5,        32'h0,        3'd0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'h3,        32'h5,        32'h3,        3'd0, 0, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd3, 32'h0,        32'h5,        32'h3,        3'd3, 1, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 32'h0,        32'h5,        32'h3,        3'd3, 0, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 3'd4, 32'h8,        32'h8,        32'h3,        3'd3, 0, 1, 1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0,        32'h8,        32'h3,        3'd3, 0, 1, 1, 0);
    tbl[6]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 3'd0, 32'h9,        32'h0,        32'h3,        3'd3, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 3'd5, 32'h0,        32'h0,        32'h3,        3'd3, 0, 0, 1, 1);
    tbl[8]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 3'd0, 32'h12345678, 32'h12345678, 32'h12345678, 3'd3, 0, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 3'd0, 32'h0,        32'h12345678, 32'h0,        3'd3, 0, 1, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 3'd3, 0, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd7, 32'h0,        32'h12345678, 32'hFFFFFFFF, 3'd7, 1, 1, 1, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, 1, 3'd0, 32'h1,        32'h12345678, 32'hFFFFFFFF, 3'd7, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 32'h0,        32'h12345678, 32'hFFFFFFFF, 3'd7, 0, 1, 1, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 0, 3'd6, 32'h0,        32'h12345678, 32'hFFFFFFFF, 3'd6, 1, 1, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 32'h0,        32'h12345678, 32'hFFFFFFFF, 3'd6, 0, 1, 1, 0);

    #12;
    chk("reset op_valid", {31'd0, v0}, 32'd0);
    chk("reset operand_A", a0, 32'd0);
    chk("reset A_loaded", {31'd0, la0}, 32'd0);
    chk("reset cmd_ready", {31'd0, rdy0}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // stall in ISSUE: held outputs, writes ignored
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h5, 32'h5, 32'hFFFFFFFF, 3'd6, 0, 1, 1, 0), "stall_wa");
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'h3, 32'h5, 32'h3, 3'd6, 0, 1, 1, 0), "stall_wb");
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd3, 32'h0, 32'h5, 32'h3, 3'd3, 1, 1, 1, 0), "stall_rd");
    for (int i = 0; i < 4; i++)
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 32'hFFFFFFFF, 32'h5, 32'h3, 3'd3, 1, 1, 1, 0),
            $sformatf("stall%0d", i));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 32'h0, 32'h5, 32'h3, 3'd3, 0, 1, 1, 0), "stall_rel");

    // read with only A loaded after a fresh reset
    do_reset();
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h7, 32'h7, 32'h0, 3'd0, 0, 1, 0, 0), "err_wa");
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd4, 32'h0, 32'h7, 32'h0, 3'd0, 0, 1, 0, 1), "err_rd");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h7, 32'h0, 3'd0, 0, 1, 0, 0), "err_end");

    // asynchronous reset between edges while in ISSUE
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'h3, 32'h7, 32'h3, 3'd0, 0, 1, 1, 0), "ar_wb");
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd4, 32'h0, 32'h7, 32'h3, 3'd4, 1, 1, 1, 0), "ar_rd");
    @(negedge clk);
    cmd_valid = 1'b0; read_A = 1'b0; read_B = 1'b0; alu_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async op_valid", {31'd0, v0}, 32'd0);
    chk("async A_loaded", {31'd0, la0}, 32'd0);
    chk("async B_loaded", {31'd0, lb0}, 32'd0);
    chk("async operand_A", a0, 32'd0);
    chk("async cmd_ready", {31'd0, rdy0}, 32'd1);
    chk("async dut1 op_valid", {31'd0, v1}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // loaded flags: kept by dut0, cleared on handshake by dut1
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h1, 32'h1, 32'h0, 3'd0, 0, 1, 0, 0), "coi_wa");
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 32'h2, 32'h1, 32'h2, 3'd0, 0, 1, 1, 0), "coi_wb");
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd5, 32'h0, 32'h1, 32'h2, 3'd5, 1, 1, 1, 0), "coi_rd");
    chk("coi dut1 A_loaded in ISSUE", {31'd0, la1}, 32'd1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 32'h0, 32'h1, 32'h2, 3'd5, 0, 1, 1, 0), "coi_hs");
    chk("coi dut1 A_loaded", {31'd0, la1}, 32'd0);
    chk("coi dut1 B_loaded", {31'd0, lb1}, 32'd0);
    chk("coi dut1 operand_A", a1, 32'h1);
    chk("coi dut1 op_valid", {31'd0, v1}, 32'd0);
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 3'd7, 32'h0, 32'h1, 32'h2, 3'd7, 1, 1, 1, 0), "coi_rd2");
    chk("coi dut1 read_error", {31'd0, err1}, 32'd1);
    chk("coi dut1 op_valid after err", {31'd0, v1}, 32'd0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_register_unit.md
Name: operand_register_unit

Overview:
Consumes the per-instruction control flags (write_A, write_B, reset_A, reset_B, read_A, read_B) produced by the instruction flag decoder. Holds the two 32-bit operand registers A and B. Issues operand pairs plus opcode to the ALU over a valid/ready handshake. Sits between the instruction flag decoder and the ALU in the datapath.

Parameters:
DATA_WIDTH, 32, width of operand registers and data_in.
CLEAR_ON_ISSUE, 0, when 1 the A/B loaded flags clear on a completed ALU handshake.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_valid  input  1  flags/opcode/data_in valid this cycle.
cmd_ready  output  1  unit accepts a command this cycle.
write_A  input  1  load A from data_in.
write_B  input  1  load B from data_in.
reset_A  input  1  clear A.
reset_B  input  1  clear B.
read_A  input  1  read request (with read_B: issue to ALU).
read_B  input  1  read request (with read_A: issue to ALU).
opcode  input  3  instruction[38:36] of the current instruction.
data_in  input  DATA_WIDTH  instruction immediate data, instruction[31:0].
operand_A  output  DATA_WIDTH  register A contents.
operand_B  output  DATA_WIDTH  register B contents.
alu_op  output  3  opcode latched at issue.
op_valid  output  1  operand pair valid to ALU.
alu_ready  input  1  ALU accepts operand pair.
A_loaded  output  1  A written since last clear.
B_loaded  output  1  B written since last clear.
read_error  output  1  one-cycle pulse: read with an operand not loaded.

Behaviour:
- Reset (reset=0, async): A=0, B=0, alu_op=0, A_loaded=0, B_loaded=0, op_valid=0, read_error=0, state IDLE. Reset takes effect mid-handshake: op_valid drops immediately, the transaction is lost.
- States: IDLE, ISSUE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted on a clk edge with cmd_valid=1.
  - Per-register priority: reset_X > write_X.
  - reset_X: X<=0, X_loaded<=0.
  - write_X: X<=data_in, X_loaded<=1.
  - write_A and write_B together: both load the same data_in.
- Read command (read_A or read_B asserted):
  - Requires A_loaded and B_loaded as they stand before this cycle's updates.
  - If met: alu_op<=opcode, transition to ISSUE, op_valid=1 from the next cycle.
  - If not met: read_error=1 for exactly one cycle, state stays IDLE, registers unchanged.
  - A read combined with any write/reset in the same command: the writes/resets apply, the read is treated as error (read_error pulse).
- cmd_valid=0: no state change. Flags are don't-care.
- ISSUE:
  - cmd_ready=0, op_valid=1.
  - operand_A, operand_B and alu_op are held stable.
  - On a clk edge with alu_ready=1: return to IDLE, op_valid=0 next cycle. If CLEAR_ON_ISSUE=1, A_loaded and B_loaded clear on that edge.
  - alu_ready=0: stay in ISSUE indefinitely.
- Latency:
  - Accepted write/reset is visible on outputs 1 cycle after the edge.
  - Read-to-op_valid: 1 cycle.
  - Minimum back-to-back issue rate: 1 per 2 cycles (IDLE→ISSUE→IDLE).
- alu_ready in IDLE is ignored.
- All outputs are registered except cmd_ready, which is decoded from state.

Decomposition:
- Shared package (cpu_pkg): DATA_WIDTH default, opcode constants (OP_CLR=3'b000, OP_LDA=3'b001, OP_LDB=3'b010, ALU ops 3'b011..3'b111), state encoding IDLE/ISSUE.
- One natural sub-module, operand_reg: one DATA_WIDTH register with clear/load/loaded flag, instantiated twice for A and B. The handshake FSM stays in the top.

Test Plan:
- Reset release, then cmd_valid with write_A=1, data_in=32'h0000_0005 → next cycle operand_A=5, A_loaded=1, B_loaded=0, op_valid=0.
- Write A=5, write B=32'h0000_0003, then read_A=read_B=1 with opcode=3'b011 → next cycle op_valid=1, alu_op=3'b011, operand_A=5, operand_B=3, cmd_ready=0.
- In ISSUE, hold alu_ready=0 for 4 cycles while driving write_A, data_in=32'hFFFF_FFFF → op_valid stays 1 and operand_A stays 5. Then alu_ready=1 → op_valid=0 next cycle, cmd_ready=1.
- After reset, write only A=7, then read → read_error=1 for one cycle, op_valid stays 0, state IDLE.
- Command with reset_A=1 and write_A=1, data_in=9 → operand_A=0, A_loaded=0.
- Drive reset=0 asynchronously mid-ISSUE (between edges) → op_valid, A_loaded, B_loaded go 0 immediately. With CLEAR_ON_ISSUE=1, a completed handshake → A_loaded=B_loaded=0.
